// File: rtl/bcd_count_pkg.sv
// Shared definitions for the BCD up/down counter.
//   bcd_digit_t   : one packed BCD digit (legal values 0..9)
//   speed_e       : step-rate select, step rate = 1 Hz << speed
//   SEG_0..SEG_9  : active-high {g,f,e,d,c,b,a} patterns
//   seg_pattern() : digit -> active-high segment pattern (blank if not BCD)
//   clamp_digit() : forces any non-BCD nibble to 9
package bcd_count_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        SPEED_1HZ = 2'd0,
        SPEED_2HZ = 2'd1,
        SPEED_4HZ = 2'd2,
        SPEED_8HZ = 2'd3
    } speed_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] seg_pattern(input bcd_digit_t d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    function automatic bcd_digit_t clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to 7-segment decoder, purely combinational.
//   digit [3:0] : BCD digit in
//   seg   [6:0] : {g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW != 0
module bcd_to_seg7
    import bcd_count_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pattern(digit);
        if (SEG_ACTIVE_LOW != 0) begin
            seg = ~seg;
        end
    end

endmodule

// File: rtl/bcd_count_nd.sv
// NUM_DIGITS-digit BCD up/down counter stepped by a prescaler at 1/2/4/8 Hz,
// with wrap or saturate at the terminal value, preset load and 7-seg decode.
//   clk, rst     : clock, synchronous active-high reset
//   en           : count enable (freezes prescaler and digits when 0)
//   dir          : 0 = up, 1 = down
//   speed [1:0]  : step rate = 1 Hz << speed
//   sat          : 0 = wrap at terminal, 1 = hold at terminal
//   load_valid   : preset request, accepted when load_ready is high
//   load_bcd     : preset value, digit 0 in [3:0]; non-BCD digits load as 9
//   load_ready   : low during reset and the first cycle after it
//   bcd          : current count, same packing as load_bcd
//   seg          : 7 segment bits per digit, digit 0 in [6:0]
//   tick         : one-cycle pulse with each step (including held steps)
//   term         : one-cycle pulse on a step attempted from the terminal value
module bcd_count_nd
    import bcd_count_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    dir,
    input  logic [1:0]              speed,
    input  logic                    sat,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic                    load_ready,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    tick,
    output logic                    term
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int PS_W  = $clog2(CLK_HZ);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             tick_q, tick_d;
    logic             term_q, term_d;
    logic             ready_q, ready_d;
    logic [1:0]       speed_q, speed_d;

    speed_e           speed_sel;
    logic [PS_W-1:0]  per_m1;
    logic             speed_chg;
    logic             presc_clear;
    logic             step;
    logic             at_term;
    logic             load_take;
    logic [BCD_W-1:0] up_next, dn_next, load_clamped;

    assign speed_sel  = speed_e'(speed);
    assign load_ready = ready_q & ~rst;
    assign load_take  = load_valid & load_ready;

    // Digit-serial increment/decrement with ripple carry/borrow, plus
    // terminal detection and load sanitising.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic       all9;
        logic       all0;
        bcd_digit_t d;
        carry        = 1'b1;
        borrow       = 1'b1;
        all9         = 1'b1;
        all0         = 1'b1;
        d            = '0;
        up_next      = bcd_q;
        dn_next      = bcd_q;
        load_clamped = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = bcd_q[4*k +: 4];
            if (d != 4'd9) all9 = 1'b0;
            if (d != 4'd0) all0 = 1'b0;
            if (carry) begin
                up_next[4*k +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                carry             = (d == 4'd9);
            end
            if (borrow) begin
                dn_next[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                borrow            = (d == 4'd0);
            end
            load_clamped[4*k +: 4] = clamp_digit(load_bcd[4*k +: 4]);
        end
        at_term = dir ? all0 : all9;
    end

    // Prescaler terminal count for the current speed. A speed change that
    // leaves the prescaler at or beyond the new terminal count clears it
    // without stepping, so a speed-up never produces a spurious early tick.
    always_comb begin
        per_m1      = PS_W'((CLK_HZ >> speed_sel) - 1);
        speed_chg   = (speed != speed_q);
        presc_clear = en && ((presc_q > per_m1) ||
                             (speed_chg && (presc_q == per_m1)));
        step        = en && !presc_clear && (presc_q == per_m1);
    end

    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        tick_d  = 1'b0;
        term_d  = 1'b0;
        ready_d = 1'b1;
        speed_d = speed;
        if (load_take) begin
            // Load wins over a coincident step: no tick/term this cycle.
            bcd_d   = load_clamped;
            presc_d = '0;
        end else if (presc_clear) begin
            presc_d = '0;
        end else if (step) begin
            presc_d = '0;
            tick_d  = 1'b1;
            term_d  = at_term;
            if (!(at_term && sat)) begin
                bcd_d = dir ? dn_next : up_next;
            end
        end else if (en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            term_q  <= 1'b0;
            ready_q <= 1'b0;
            speed_q <= '0;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            tick_q  <= tick_d;
            term_q  <= term_d;
            ready_q <= ready_d;
            speed_q <= speed_d;
        end
    end

    assign bcd  = bcd_q;
    assign tick = tick_q;
    assign term = term_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        bcd_to_seg7 #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_seg (
            .digit(bcd_q[4*g +: 4]),
            .seg  (seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_bcd_count_nd.sv
// Directed bench for bcd_count_nd (CLK_HZ=16, NUM_DIGITS=4). Expected step
// results (value, term, cycle) are queued as stimulus is applied and popped
// by a negedge monitor whenever tick is seen.
module tb_bcd_count_nd;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dir;
    logic [1:0]  speed;
    logic        sat;
    logic        load_valid;
    logic [15:0] load_bcd;
    logic        load_ready;
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        tick;
    logic        term;

    typedef struct {
        logic [15:0] bcd;
        logic        term;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   c0;

    bcd_count_nd #(
        .NUM_DIGITS    (4),
        .CLK_HZ        (16),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .speed     (speed),
        .sat       (sat),
        .load_valid(load_valid),
        .load_bcd  (load_bcd),
        .load_ready(load_ready),
        .bcd       (bcd),
        .seg       (seg),
        .tick      (tick),
        .term      (term)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v, input logic t, input int c);
        exp_t e;
        e.bcd  = v;
        e.term = t;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Monitor: every tick must match the next queued step; term only with tick.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (tick === 1'b1) begin
                chk("tick_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("step_bcd", 32'(bcd), 32'(e.bcd));
                    chk("step_term", 32'(term), 32'(e.term));
                    chk("step_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("term_without_tick", 32'(term), 32'd0);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        dir        = 1'b0;
        speed      = 2'd0;
        sat        = 1'b0;
        load_valid = 1'b0;
        load_bcd   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_term", 32'(term), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h0);
        chk("rst_seg", 32'(seg), 32'({4{7'h3F}}));
        rst = 1'b0;
        #1;
        chk("ready_first_cycle", 32'(load_ready), 32'h0);
        @(posedge clk); #1;
        chk("ready_second_cycle", 32'(load_ready), 32'h1);

        // Count up at 1 Hz for 160 cycles: ticks every 16 cycles
        en = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 10; k++) begin
            push((k == 10) ? 16'h0010 : 16'(k), 1'b0, c0 + 16 * k);
        end
        repeat (160) @(posedge clk);
        #1;
        chk("count_160", 32'(bcd), 32'h0010);
        en = 1'b0;

        // Load 9998 at 8 Hz, wrap through terminal
        c0 = cyc;
        load_valid = 1'b1;
        load_bcd   = 16'h9998;
        speed      = 2'd3;
        sat        = 1'b0;
        dir        = 1'b0;
        en         = 1'b1;
        push(16'h9999, 1'b0, c0 + 3);
        push(16'h0000, 1'b1, c0 + 5);
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("load_9998", 32'(bcd), 32'h9998);
        repeat (4) @(posedge clk);
        #1;
        chk("wrap_0000", 32'(bcd), 32'h0000);
        en = 1'b0;

        // Load 0001, count down, saturate at 0000
        c0 = cyc;
        load_valid = 1'b1;
        load_bcd   = 16'h0001;
        dir        = 1'b1;
        sat        = 1'b1;
        speed      = 2'd0;
        en         = 1'b1;
        push(16'h0000, 1'b0, c0 + 17);
        push(16'h0000, 1'b1, c0 + 33);
        push(16'h0000, 1'b1, c0 + 49);
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        chk("hold_0000", 32'(bcd), 32'h0000);
        en = 1'b0;

        // Non-BCD load digits clamp to 9
        load_valid = 1'b1;
        load_bcd   = 16'hF9A3;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("load_clamp", 32'(bcd), 32'h9993);
        chk("load_clamp_tick", 32'(tick), 32'h0);

        // Load coincident with a due step: load wins, no tick
        en    = 1'b1;
        speed = 2'd3;
        dir   = 1'b0;
        sat   = 1'b0;
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_bcd   = 16'h1234;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("load_wins_bcd", 32'(bcd), 32'h1234);
        chk("load_wins_tick", 32'(tick), 32'h0);
        chk("load_wins_term", 32'(term), 32'h0);
        chk("seg_1234", 32'(seg), 32'({7'h06, 7'h5B, 7'h4F, 7'h66}));

        // Speed 0 -> 3 with prescaler at 10: clear without step, tick 2 later
        speed = 2'd0;
        c0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        speed = 2'd3;
        push(16'h1235, 1'b0, c0 + 13);
        @(posedge clk); #1;
        chk("speed_clear_tick", 32'(tick), 32'h0);
        chk("speed_clear_bcd", 32'(bcd), 32'h1234);
        repeat (2) @(posedge clk);
        #1;
        chk("speed_next_bcd", 32'(bcd), 32'h1235);

        // Reset mid-count at 0457
        en         = 1'b0;
        load_valid = 1'b1;
        load_bcd   = 16'h0457;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("load_0457", 32'(bcd), 32'h0457);
        en    = 1'b1;
        speed = 2'd0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ready_in_rst", 32'(load_ready), 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_bcd", 32'(bcd), 32'h0000);
        chk("mid_rst_tick", 32'(tick), 32'h0);
        chk("mid_rst_term", 32'(term), 32'h0);
        chk("mid_rst_seg", 32'(seg), 32'({4{7'h3F}}));
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_low", 32'(load_ready), 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_ready_high", 32'(load_ready), 32'h1);
        en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
